pll_reset_sequencer: RTL and testbench

- Supervises an external PLL; runs entirely on the PLL reference clock.
- Drives the PLL reset, waits for lock with a timeout, and retries a bounded number of times.
- Once lock has been stable for a set time, releases NUM_CHANNELS downstream resets in a staggered order.
- Successor to the fixed two-output PLL wrapper: channel count and timings are parametrised, and it adds lock supervision, retry, fault and lock-loss recovery.

---
 rtl/pll_seq_pkg.sv | 31 +++
 rtl/bit_sync.sv | 34 +++
 rtl/pll_reset_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : pll_seq_pkg                                                      |
// | Shared state encoding and sizing helpers for pll_reset_sequencer.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } seq_state_e;

    localparam int c_lock_loss_w = 8;

    // The single shared timer must reach the last cycle of the longest interval.
    function automatic int timer_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bit_sync                                                         |
// | Two-flop synchroniser for a single asynchronous level.                     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bit_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], i_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pll_reset_sequencer                                              |
// | PLL supervisor: reset/lock/retry, then staggered channel reset release.    |
// | Option  : PLL_SEQ_LOCK_LOSS_COUNTER_EN adds a saturating lock-loss count.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_CHANNELS       = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGGER_CYCLES     = 256,
    parameter int MAX_RETRIES        = 3
) (
    input  logic                             refclk,
    input  logic                             rst,
    input  logic                             pll_locked,
    output logic                             pll_rst,
    output logic [NUM_CHANNELS-1:0]          chan_rst,
    output logic                             ready,
    output logic                             fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
`ifdef PLL_SEQ_LOCK_LOSS_COUNTER_EN
    ,
    output logic [c_lock_loss_w-1:0]         lock_loss_count
`endif
);

    localparam int c_timer_w = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT,
                                           LOCK_STABLE_CYCLES, STAGGER_CYCLES);
    localparam int c_retry_w = $clog2(MAX_RETRIES + 1);

    localparam logic [c_timer_w-1:0] c_rst_last     = c_timer_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_timeout_last = c_timer_w'(LOCK_TIMEOUT - 1);
    // The edge entering STABLE already counts as the first stable cycle.
    localparam logic [c_timer_w-1:0] c_stable_last  =
        c_timer_w'((LOCK_STABLE_CYCLES > 1) ? (LOCK_STABLE_CYCLES - 2) : 0);
    localparam logic [c_timer_w-1:0] c_stagger_last = c_timer_w'(STAGGER_CYCLES - 1);
    localparam logic [c_retry_w-1:0] c_retry_max    = c_retry_w'(MAX_RETRIES);

    logic                    lock_s;
    seq_state_e              state_q, state_d;
    logic [c_timer_w-1:0]    timer_q, timer_d;
    logic                    pll_rst_q, pll_rst_d;
    logic [NUM_CHANNELS-1:0] chan_rst_q, chan_rst_d;
    logic                    ready_q, ready_d;
    logic                    fault_q, fault_d;
    logic [c_retry_w-1:0]    retry_q, retry_d;

    logic [c_timer_w-1:0]    w_timer_inc;
    logic [c_retry_w-1:0]    w_retry_inc;
    logic [NUM_CHANNELS-1:0] w_chan_next;
    logic                    w_lock_loss;

    bit_sync #(
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .i_d (pll_locked),
        .o_q (lock_s)
    );

    always_comb begin
        w_timer_inc = timer_q + 1'b1;
        w_retry_inc = retry_q + 1'b1;
        w_chan_next = chan_rst_q << 1;
        w_lock_loss = !lock_s && ((state_q == RELEASE) || (state_q == RUN));
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        pll_rst_d  = pll_rst_q;
        chan_rst_d = chan_rst_q;
        ready_d    = ready_q;
        fault_d    = fault_q;
        retry_d    = retry_q;

        if (w_lock_loss) begin
            state_d    = PLL_RESET;
            timer_d    = '0;
            pll_rst_d  = 1'b1;
            chan_rst_d = '1;
            ready_d    = 1'b0;
        end else begin
            case (state_q)
                PLL_RESET: begin
                    if (timer_q == c_rst_last) begin
                        state_d   = WAIT_LOCK;
                        timer_d   = '0;
                        pll_rst_d = 1'b0;
                    end else begin
                        timer_d = w_timer_inc;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        timer_d = '0;
                    end else if (timer_q == c_timeout_last) begin
                        timer_d   = '0;
                        pll_rst_d = 1'b1;
                        retry_d   = w_retry_inc;
                        if (w_retry_inc == c_retry_max) begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                        end else begin
                            state_d = PLL_RESET;
                        end
                    end else begin
                        timer_d = w_timer_inc;
                    end
                end
                STABLE, RELEASE: begin
                    if ((state_q == STABLE) && !lock_s) begin
                        state_d = WAIT_LOCK;
                        timer_d = '0;
                    end else if (((state_q == STABLE) && (timer_q == c_stable_last)) ||
                                 ((state_q == RELEASE) && (timer_q == c_stagger_last))) begin
                        // Channels release LSB first by shifting zeros in from the bottom.
                        timer_d    = '0;
                        chan_rst_d = w_chan_next;
                        if (w_chan_next == '0) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                            retry_d = '0;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        timer_d = w_timer_inc;
                    end
                end
                RUN: begin
                    timer_d = '0;
                end
                FAULT: begin
                    timer_d = '0;
                end
                default: begin
                    state_d    = PLL_RESET;
                    timer_d    = '0;
                    pll_rst_d  = 1'b1;
                    chan_rst_d = '1;
                    ready_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q    <= PLL_RESET;
            timer_q    <= '0;
            pll_rst_q  <= 1'b1;
            chan_rst_q <= '1;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
            retry_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pll_rst_q  <= pll_rst_d;
            chan_rst_q <= chan_rst_d;
            ready_q    <= ready_d;
            fault_q    <= fault_d;
            retry_q    <= retry_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign chan_rst    = chan_rst_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;

`ifdef PLL_SEQ_LOCK_LOSS_COUNTER_EN
    logic [c_lock_loss_w-1:0] lock_loss_q, lock_loss_d;

    always_comb begin
        lock_loss_d = lock_loss_q;
        if (w_lock_loss && (lock_loss_q != '1)) begin
            lock_loss_d = lock_loss_q + 1'b1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_loss_q <= '0;
        end else begin
            lock_loss_q <= lock_loss_d;
        end
    end

    assign lock_loss_count = lock_loss_q;
`else
    // Lock-loss events only force the restart through PLL_RESET in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pll_reset_sequencer                                           |
// | Self-checking bench for pll_reset_sequencer (small timing parameters).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    localparam int NUM_CHANNELS       = 3;
    localparam int PLL_RST_CYCLES     = 4;
    localparam int LOCK_TIMEOUT       = 64;
    localparam int LOCK_STABLE_CYCLES = 8;
    localparam int STAGGER_CYCLES     = 4;
    localparam int MAX_RETRIES        = 2;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic [2:0] chan_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
`ifdef PLL_SEQ_LOCK_LOSS_COUNTER_EN
    logic [7:0] lock_loss_count;
`endif

    pll_reset_sequencer #(
        .NUM_CHANNELS       (NUM_CHANNELS),
        .PLL_RST_CYCLES     (PLL_RST_CYCLES),
        .LOCK_TIMEOUT       (LOCK_TIMEOUT),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .STAGGER_CYCLES     (STAGGER_CYCLES),
        .MAX_RETRIES        (MAX_RETRIES)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .chan_rst    (chan_rst),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count)
`ifdef PLL_SEQ_LOCK_LOSS_COUNTER_EN
        ,
        .lock_loss_count (lock_loss_count)
`endif
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic       pll_rst;
        logic [2:0] chan_rst;
        logic       ready;
        logic       fault;
        logic [1:0] retry;
    } outs_t;

    typedef struct {
        string name;
        bit    do_rst;
        int    cyc;
        logic  lock_in;
        outs_t exp;
    } vec_t;

    typedef struct {
        string name;
        outs_t exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    function automatic outs_t mk(logic pr, logic [2:0] cr, logic rdy, logic flt, logic [1:0] rc);
        return {pr, cr, rdy, flt, rc};
    endfunction

    task automatic add(string name, bit do_rst, int c, logic lk, outs_t e);
        vec_t v;
        v.name    = name;
        v.do_rst  = do_rst;
        v.cyc     = c;
        v.lock_in = lk;
        v.exp     = e;
        vecs.push_back(v);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(negedge refclk);
            cyc++;
        end
    endtask

    task automatic apply_reset(logic lk);
        @(negedge refclk);
        rst        = 1'b1;
        pll_locked = lk;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic expect_out(string name, outs_t e);
        sb_t s;
        s.name = name;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic compare_out();
        sb_t   s;
        outs_t act;
        act = {pll_rst, chan_rst, ready, fault, retry_count};
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got %b, no expected entry", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                n_err++;
                $display("FAIL %s @cyc %0d: got pll_rst=%b chan_rst=%b ready=%b fault=%b retry=%0d, want pll_rst=%b chan_rst=%b ready=%b fault=%b retry=%0d",
                         s.name, cyc, act.pll_rst, act.chan_rst, act.ready, act.fault, act.retry,
                         s.exp.pll_rst, s.exp.chan_rst, s.exp.ready, s.exp.fault, s.exp.retry);
            end
        end
    endtask

    task automatic check_now(string name, outs_t e);
        expect_out(name, e);
        compare_out();
    endtask

`ifdef PLL_SEQ_LOCK_LOSS_COUNTER_EN
    task automatic check_ll(string name, logic [7:0] e);
        n_cmp++;
        if (lock_loss_count !== e) begin
            n_err++;
            $display("FAIL %s: got lock_loss_count=%0d, want %0d", name, lock_loss_count, e);
        end
    endtask

    // One relock reaching RELEASE/RUN followed by a lock drop there.
    task automatic lock_loss_cycle();
        pll_locked = 1'b1;
        tick(20);
        pll_locked = 1'b0;
        tick(8);
    endtask
`endif

    task automatic run_rows();
        foreach (vecs[i]) begin
            if (vecs[i].do_rst) apply_reset(vecs[i].lock_in);
            expect_out(vecs[i].name, vecs[i].exp);
            while (cyc < vecs[i].cyc) tick(1);
            compare_out();
            pll_locked = vecs[i].lock_in;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want summary");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;

        // Nominal: rst released at cycle 0, pll_rst falls at 4, lock at 14,
        // lock_s seen at 17, release 24/28/32.
        add("nom_reset",       1,  0, 1'b0, mk(1'b1, 3'b111, 1'b0, 1'b0, 2'd0));
        add("nom_pllrst_hold", 0,  3, 1'b0, mk(1'b1, 3'b111, 1'b0, 1'b0, 2'd0));
        add("nom_pllrst_fall", 0,  4, 1'b0, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("nom_lock_rise",   0, 14, 1'b1, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("nom_pre_rel0",    0, 23, 1'b1, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("nom_rel0",        0, 24, 1'b1, mk(1'b0, 3'b110, 1'b0, 1'b0, 2'd0));
        add("nom_pre_rel1",    0, 27, 1'b1, mk(1'b0, 3'b110, 1'b0, 1'b0, 2'd0));
        add("nom_rel1",        0, 28, 1'b1, mk(1'b0, 3'b100, 1'b0, 1'b0, 2'd0));
        add("nom_pre_ready",   0, 31, 1'b1, mk(1'b0, 3'b100, 1'b0, 1'b0, 2'd0));
        add("nom_ready",       0, 32, 1'b1, mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0));
        add("nom_run_hold",    0, 40, 1'b1, mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0));

        // Glitch: pll_locked low during cycle 19..20 -> lock_s low for edge 22,
        // WAIT_LOCK at 22, STABLE again at 23, release at 30.
        add("gl_reset",        1,  0, 1'b0, mk(1'b1, 3'b111, 1'b0, 1'b0, 2'd0));
        add("gl_lock_rise",    0, 14, 1'b1, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("gl_drop",         0, 19, 1'b0, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("gl_restore",      0, 20, 1'b1, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("gl_in_wait",      0, 22, 1'b1, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("gl_no_early_rel", 0, 24, 1'b1, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("gl_pre_rel0",     0, 29, 1'b1, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("gl_rel0",         0, 30, 1'b1, mk(1'b0, 3'b110, 1'b0, 1'b0, 2'd0));
        add("gl_ready",        0, 38, 1'b1, mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0));

        // Timeout: WAIT_LOCK from 4, timeout at 68, retry PLL_RESET 68..72,
        // second timeout at 136 -> FAULT, which ignores a later lock.
        add("to_reset",        1,   0, 1'b0, mk(1'b1, 3'b111, 1'b0, 1'b0, 2'd0));
        add("to_pre_timeout",  0,  67, 1'b0, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("to_timeout1",     0,  68, 1'b0, mk(1'b1, 3'b111, 1'b0, 1'b0, 2'd1));
        add("to_retry_hold",   0,  71, 1'b0, mk(1'b1, 3'b111, 1'b0, 1'b0, 2'd1));
        add("to_retry_fall",   0,  72, 1'b0, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd1));
        add("to_pre_timeout2", 0, 135, 1'b0, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd1));
        add("to_fault",        0, 136, 1'b1, mk(1'b1, 3'b111, 1'b0, 1'b1, 2'd2));
        add("to_fault_hold",   0, 300, 1'b1, mk(1'b1, 3'b111, 1'b0, 1'b1, 2'd2));

        // Lock loss in RUN: drop at 40, chan_rst back at 43, relock at 47.
        add("ll_reset",        1,  0, 1'b0, mk(1'b1, 3'b111, 1'b0, 1'b0, 2'd0));
        add("ll_lock_rise",    0, 14, 1'b1, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("ll_ready",        0, 32, 1'b1, mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0));
        add("ll_drop",         0, 40, 1'b0, mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0));
        add("ll_sync_delay",   0, 42, 1'b0, mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0));
        add("ll_reassert",     0, 43, 1'b0, mk(1'b1, 3'b111, 1'b0, 1'b0, 2'd0));
        add("ll_pllrst_hold",  0, 46, 1'b0, mk(1'b1, 3'b111, 1'b0, 1'b0, 2'd0));
        add("ll_pllrst_fall",  0, 47, 1'b1, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("ll_pre_rel0",     0, 56, 1'b1, mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        add("ll_rel0",         0, 57, 1'b1, mk(1'b0, 3'b110, 1'b0, 1'b0, 2'd0));
        add("ll_ready",        0, 65, 1'b1, mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0));

        run_rows();

        // Async reset between chan_rst[0] and chan_rst[1], off the clock edge.
        apply_reset(1'b0);
        tick(14);
        pll_locked = 1'b1;
        tick(10);
        check_now("ar_rel0", mk(1'b0, 3'b110, 1'b0, 1'b0, 2'd0));
        #2;
        rst = 1'b1;
        #1;
        check_now("ar_immediate", mk(1'b1, 3'b111, 1'b0, 1'b0, 2'd0));
        @(negedge refclk);
        rst = 1'b0;
        cyc = 0;
        // Lock held high: lock_s is up before WAIT_LOCK, so STABLE at 5, release at 12.
        tick(4);
        check_now("ar_pllrst_fall", mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        tick(7);
        check_now("ar_pre_rel0", mk(1'b0, 3'b111, 1'b0, 1'b0, 2'd0));
        tick(1);
        check_now("ar_rel0_again", mk(1'b0, 3'b110, 1'b0, 1'b0, 2'd0));
        tick(4);
        check_now("ar_rel1", mk(1'b0, 3'b100, 1'b0, 1'b0, 2'd0));
        tick(4);
        check_now("ar_ready", mk(1'b0, 3'b000, 1'b1, 1'b0, 2'd0));

`ifdef PLL_SEQ_LOCK_LOSS_COUNTER_EN
        apply_reset(1'b0);
        check_ll("llc_reset", 8'd0);
        repeat (2) lock_loss_cycle();
        check_ll("llc_two_events", 8'd2);
        repeat (298) lock_loss_cycle();
        check_ll("llc_saturate", 8'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
